// File: rtl/alu_cmd_queue_pkg.sv
// alu_cmd_queue_pkg
//   Shared definitions for the ALU command queue:
//   - ALU_W        : operand/result width of the downstream alu
//   - ALUOP_*      : 3-bit ALU opcode map (110/111 are illegal)
//   - CMD_W        : width of one queued command {a, b, op}
//   - alu_cmd_t    : packed command record stored in the FIFO
//   - is_illegal_op: flags opcodes the alu does not define
package alu_cmd_queue_pkg;

  localparam int ALU_W = 32;
  localparam int CMD_W = 2 * ALU_W + 3;

  localparam logic [2:0] ALUOP_ADD = 3'b000;
  localparam logic [2:0] ALUOP_SUB = 3'b001;
  localparam logic [2:0] ALUOP_AND = 3'b010;
  localparam logic [2:0] ALUOP_OR  = 3'b011;
  localparam logic [2:0] ALUOP_SRL = 3'b100;
  localparam logic [2:0] ALUOP_SRA = 3'b101;

  typedef struct packed {
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    logic [2:0]       op;
  } alu_cmd_t;

  // Opcodes 110 and 111 have no alu meaning; the result is still captured.
  function automatic logic is_illegal_op(input logic [2:0] op);
    return (op >= 3'b110);
  endfunction

endpackage

// File: rtl/alu_cmd_queue_cmd_fifo.sv
// alu_cmd_queue_cmd_fifo
//   Synchronous DEPTH-entry FIFO for ALU commands with first-word
//   fall-through read (rdata is always the head entry).
//   Ports:
//     clk, rst_n  : clock, async active-low reset
//     flush       : synchronous clear, wins over push/pop
//     push, wdata : write request and data (ignored when full)
//     pop         : read request (ignored when empty)
//     rdata       : head entry (undefined content when empty)
//     full, empty : occupancy flags derived from the entry count
module alu_cmd_queue_cmd_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 67
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign push_ok_s = push & ~full & ~flush;
  assign pop_ok_s  = pop & ~empty & ~flush;
  assign rdata     = mem_r[rd_ptr_r];

  // Pointer and count state; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are only observed through valid head reads.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

endmodule

// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue
//   Buffers ALU commands from decode, presents the head command to the
//   combinational alu and captures alu_c into a result register behind a
//   valid/ready handshake.
//   Ports:
//     clk, rst_n              : clock, async active-low reset
//     flush                   : sync clear of queue and pending result
//     in_valid/in_ready       : command handshake (in_ready = !full)
//     in_a, in_b, in_op       : command operands and opcode
//     alu_a, alu_b, alu_op    : head command to alu (zero when empty)
//     alu_c                   : alu result
//     res_valid/res_ready     : result handshake
//     res_data, res_err       : captured result, illegal-op flag
module alu_cmd_queue
  import alu_cmd_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ALU_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [2:0]   in_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_c,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         res_err
);

  alu_cmd_t   wr_cmd_s;
  alu_cmd_t   head_cmd_s;
  logic       full_s;
  logic       empty_s;
  logic       push_s;
  logic       pop_s;
  logic       deq_s;
  logic       res_valid_r;
  logic [W-1:0] res_data_r;
  logic       res_err_r;

  // in_ready depends only on the registered count, never on res_ready,
  // so a full queue refuses a push even in a cycle that pops.
  assign in_ready = ~full_s;
  assign push_s   = in_valid & ~full_s;
  assign pop_s    = ~empty_s & (~res_valid_r | res_ready);
  assign deq_s    = res_valid_r & res_ready;

  assign wr_cmd_s = '{a: in_a, b: in_b, op: in_op};

  alu_cmd_queue_cmd_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (CMD_W)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push_s),
    .wdata (wr_cmd_s),
    .pop   (pop_s),
    .rdata (head_cmd_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Drive the alu from the head entry, forcing zeros while the queue is empty.
  always_comb begin
    alu_a  = {W{1'b0}};
    alu_b  = {W{1'b0}};
    alu_op = 3'b000;
    if (!empty_s) begin
      alu_a  = head_cmd_s.a;
      alu_b  = head_cmd_s.b;
      alu_op = head_cmd_s.op;
    end else begin
      alu_a  = {W{1'b0}};
      alu_b  = {W{1'b0}};
      alu_op = 3'b000;
    end
  end

  // Result slot: capture on pop, release on dequeue, drop the pending result on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_r <= 1'b0;
      res_data_r  <= {W{1'b0}};
      res_err_r   <= 1'b0;
    end else if (flush) begin
      res_valid_r <= 1'b0;
    end else if (pop_s) begin
      res_valid_r <= 1'b1;
      res_data_r  <= alu_c;
      res_err_r   <= is_illegal_op(head_cmd_s.op);
    end else if (deq_s) begin
      res_valid_r <= 1'b0;
    end else begin
      res_valid_r <= res_valid_r;
    end
  end

  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;
  assign res_err   = res_err_r;

endmodule
